// File: rtl/game_pkg.sv
// Shared types for the game controller and the maze FSM that it drives.
package game_pkg;

    // Controller states, 3-bit so the encoding fits the status debug views.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WON   = 3'd4,
        ST_LOST  = 3'd5
    } state_e;

    // Direction encoding; also the bit index of each button/move in 4-bit vectors.
    typedef enum logic [1:0] {
        DIR_W = 2'd0,
        DIR_N = 2'd1,
        DIR_S = 2'd2,
        DIR_E = 2'd3
    } dir_e;

    // Reduce a set of simultaneous button edges to a single move, N > E > S > W.
    function automatic logic [3:0] pick_move(input logic [3:0] edges);
        logic [3:0] sel;
        sel = 4'b0000;
        if (edges[DIR_N])      sel[DIR_N] = 1'b1;
        else if (edges[DIR_E]) sel[DIR_E] = 1'b1;
        else if (edges[DIR_S]) sel[DIR_S] = 1'b1;
        else if (edges[DIR_W]) sel[DIR_W] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/game_ctrl_edge_det.sv
// Rising-edge detector for the (already synchronised) direction buttons.
module edge_det #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sig_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] prev_q;

    // Previous sample is tracked every cycle regardless of controller state.
    always_ff @(posedge clk) begin
        if (reset) prev_q <= '0;
        else       prev_q <= sig_i;
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: turns button presses into move pulses for the maze FSM,
// enforces a move limit and an idle timeout, and reports the game verdict.
module game_ctrl
    import game_pkg::*;
#(
    parameter int MAX_MOVES = 16,
    parameter int TIMEOUT   = 1000,
    parameter int DRAIN_CYC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btn_w,
    input  logic       btn_n,
    input  logic       btn_s,
    input  logic       btn_e,
    input  logic       win,
    input  logic       lose,
    output logic       mv_w,
    output logic       mv_n,
    output logic       mv_s,
    output logic       mv_e,
    output logic       maze_rst,
    output logic       playing,
    output logic       won,
    output logic       lost,
    output logic [7:0] moves
);

    // Drain counter is at least 2 bits wide, wider only if DRAIN_CYC needs it.
    localparam int DRAIN_W = (DRAIN_CYC > 3) ? $clog2(DRAIN_CYC + 1) : 2;

    state_e               state_q, state_d;
    logic [3:0]           btn_vec, rise;
    logic [3:0]           move_sel;
    logic                 move_issue;
    logic [7:0]           moves_q, moves_d;
    logic [15:0]          idle_q, idle_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [3:0]           mv_q;
    logic                 maze_rst_q;

    assign btn_vec = {btn_e, btn_s, btn_n, btn_w};

    edge_det #(.W(4)) u_edge_det (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (btn_vec),
        .rise_o (rise)
    );

    // A move is only taken in PLAY when no restart or verdict outranks it.
    assign move_sel   = (state_q == ST_PLAY && !start && !win && !lose) ? pick_move(rise) : 4'b0000;
    assign move_issue = |move_sel;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start outranks verdicts, win outranks lose.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_PLAY;
            ST_PLAY: begin
                if (start)           state_d = ST_CLEAR;
                else if (win)        state_d = ST_WON;
                else if (lose)       state_d = ST_LOST;
                else if (move_issue) begin
                    if (moves_q == 8'(MAX_MOVES - 1)) state_d = ST_DRAIN;
                end
                else if (idle_q == 16'(TIMEOUT - 1)) state_d = ST_LOST;
            end
            ST_DRAIN: begin
                if (start)     state_d = ST_CLEAR;
                else if (win)  state_d = ST_WON;
                else if (lose) state_d = ST_LOST;
                else if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) state_d = ST_LOST;
            end
            ST_WON, ST_LOST: if (start) state_d = ST_CLEAR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter next values; everything is zeroed on the way into CLEAR.
    always_comb begin
        moves_d = moves_q;
        idle_d  = idle_q;
        drain_d = drain_q;
        if (state_d == ST_CLEAR) begin
            moves_d = 8'd0;
            idle_d  = 16'd0;
            drain_d = '0;
        end else if (state_q == ST_PLAY) begin
            if (move_issue) begin
                if (moves_q < 8'(MAX_MOVES)) moves_d = moves_q + 8'd1;
                idle_d = 16'd0;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end else if (state_q == ST_DRAIN) begin
            drain_d = drain_q + DRAIN_W'(1);
        end
    end

    // Counters and the registered move / maze-reset pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            moves_q    <= 8'd0;
            idle_q     <= 16'd0;
            drain_q    <= '0;
            mv_q       <= 4'b0000;
            maze_rst_q <= 1'b0;
        end else begin
            moves_q    <= moves_d;
            idle_q     <= idle_d;
            drain_q    <= drain_d;
            mv_q       <= move_sel;
            maze_rst_q <= (state_d == ST_CLEAR);
        end
    end

    // Status flags decoded from the current state.
    always_comb begin
        playing = 1'b0;
        won     = 1'b0;
        lost    = 1'b0;
        unique case (state_q)
            ST_PLAY, ST_DRAIN: playing = 1'b1;
            ST_WON:            won     = 1'b1;
            ST_LOST:           lost    = 1'b1;
            default: ;
        endcase
    end

    assign mv_w     = mv_q[DIR_W];
    assign mv_n     = mv_q[DIR_N];
    assign mv_s     = mv_q[DIR_S];
    assign mv_e     = mv_q[DIR_E];
    assign maze_rst = maze_rst_q;
    assign moves    = moves_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: two instances (one attached to a small maze, one with a
// short move limit) share the stimulus; a game-rules model checks every cycle.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int MM0 = 16;
    localparam int TO0 = 10;
    localparam int MM1 = 2;
    localparam int TO1 = 1000;
    localparam int DC  = 3;

    localparam int PH_IDLE   = 0;
    localparam int PH_CLEAR  = 1;
    localparam int PH_ACTIVE = 2;
    localparam int PH_DRAIN  = 3;
    localparam int PH_WON    = 4;
    localparam int PH_LOST   = 5;

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0;
    logic btn_w = 1'b0, btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0;
    logic win0 = 1'b0, lose0 = 1'b0, win1 = 1'b0, lose1 = 1'b0;
    logic mv_w0, mv_n0, mv_s0, mv_e0, mrst0, play0, won0, lost0;
    logic mv_w1, mv_n1, mv_s1, mv_e1, mrst1, play1, won1, lost1;
    logic [7:0] moves0, moves1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_ctrl #(.MAX_MOVES(MM0), .TIMEOUT(TO0), .DRAIN_CYC(DC)) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .btn_w(btn_w), .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e),
        .win(win0), .lose(lose0),
        .mv_w(mv_w0), .mv_n(mv_n0), .mv_s(mv_s0), .mv_e(mv_e0),
        .maze_rst(mrst0), .playing(play0), .won(won0), .lost(lost0), .moves(moves0)
    );

    game_ctrl #(.MAX_MOVES(MM1), .TIMEOUT(TO1), .DRAIN_CYC(DC)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .btn_w(btn_w), .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e),
        .win(win1), .lose(lose1),
        .mv_w(mv_w1), .mv_n(mv_n1), .mv_s(mv_s1), .mv_e(mv_e1),
        .maze_rst(mrst1), .playing(play1), .won(won1), .lost(lost1), .moves(moves1)
    );

    logic [3:0] mv_v [2];
    logic [2:0] st_v [2];
    logic [7:0] mov_v [2];
    logic       mrst_v [2];
    assign mv_v[0]   = {mv_e0, mv_s0, mv_n0, mv_w0};
    assign mv_v[1]   = {mv_e1, mv_s1, mv_n1, mv_w1};
    assign st_v[0]   = {play0, won0, lost0};
    assign st_v[1]   = {play1, won1, lost1};
    assign mov_v[0]  = moves0;
    assign mov_v[1]  = moves1;
    assign mrst_v[0] = mrst0;
    assign mrst_v[1] = mrst1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dir_of(input logic [3:0] m);
        for (int d = 0; d < 4; d++) if (m[d]) return d;
        return -1;
    endfunction

    // ---------------- maze attached to dut0: winning path E,S,W,E,E ----------------
    dir_e path [5] = '{DIR_E, DIR_S, DIR_W, DIR_E, DIR_E};
    int maze_idx = 0;
    always @(posedge clk) begin
        if (mrst0) begin
            maze_idx <= 0;
            win0     <= 1'b0;
            lose0    <= 1'b0;
        end else if (!win0 && !lose0 && mv_v[0] != 4'b0) begin
            if (dir_of(mv_v[0]) == int'(path[maze_idx])) begin
                if (maze_idx == 4) win0 <= 1'b1;
                maze_idx <= maze_idx + 1;
            end else begin
                lose0 <= 1'b1;
            end
        end
    end

    // ---------------- game-rules model ----------------
    dir_e       prio [4] = '{DIR_N, DIR_E, DIR_S, DIR_W};
    int         max_m [2] = '{MM0, MM1};
    int         tmo [2] = '{TO0, TO1};
    int         ph [2], nmoves [2], quiet [2], drain_left [2];
    logic [3:0] exp_mv [2];
    logic       exp_mrst [2];
    logic [3:0] m_prev = 4'b0;
    logic       model_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [3:0] btn, rise;
        logic w, l, go;
        int pick;
        btn  = {btn_e, btn_s, btn_n, btn_w};
        rise = btn & ~m_prev;
        pick = -1;
        for (int k = 0; k < 4; k++)
            if (pick < 0 && rise[prio[k]]) pick = int'(prio[k]);
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? win0 : win1;
            l = (i == 0) ? lose0 : lose1;
            exp_mv[i]   = 4'b0;
            exp_mrst[i] = 1'b0;
            go = 1'b0;
            if (reset) begin
                ph[i] = PH_IDLE; nmoves[i] = 0; quiet[i] = 0; drain_left[i] = 0;
            end else begin
                case (ph[i])
                    PH_IDLE:  go = start;
                    PH_CLEAR: ph[i] = PH_ACTIVE;
                    PH_ACTIVE: begin
                        if (start)          go = 1'b1;
                        else if (w)         ph[i] = PH_WON;
                        else if (l)         ph[i] = PH_LOST;
                        else if (pick >= 0) begin
                            exp_mv[i][pick] = 1'b1;
                            nmoves[i]++;
                            quiet[i] = 0;
                            if (nmoves[i] == max_m[i]) begin
                                ph[i] = PH_DRAIN;
                                drain_left[i] = DC;
                            end
                        end
                        else if (quiet[i] == tmo[i] - 1) ph[i] = PH_LOST;
                        else quiet[i]++;
                    end
                    PH_DRAIN: begin
                        if (start)      go = 1'b1;
                        else if (w)     ph[i] = PH_WON;
                        else if (l)     ph[i] = PH_LOST;
                        else begin
                            drain_left[i]--;
                            if (drain_left[i] == 0) ph[i] = PH_LOST;
                        end
                    end
                    default: go = start;
                endcase
                if (go) begin
                    ph[i] = PH_CLEAR; nmoves[i] = 0; quiet[i] = 0; exp_mrst[i] = 1'b1;
                end
            end
        end
        m_prev = reset ? 4'b0 : btn;
        if (reset) model_valid = 1'b1;
    end

    function automatic int status_of(input int p);
        if (p == PH_ACTIVE || p == PH_DRAIN) return 3'b100;
        if (p == PH_WON)  return 3'b010;
        if (p == PH_LOST) return 3'b001;
        return 3'b000;
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("dut%0d_status", i), int'(st_v[i]), status_of(ph[i]));
                check($sformatf("dut%0d_moves", i), int'(mov_v[i]), nmoves[i]);
                check($sformatf("dut%0d_mv", i), int'(mv_v[i]), int'(exp_mv[i]));
                check($sformatf("dut%0d_maze_rst", i), int'(mrst_v[i]), int'(exp_mrst[i]));
            end
        end
    end

    // Pulse tallies for the directed scenarios.
    int n_mv0 [4] = '{0, 0, 0, 0};
    int n_mv1 = 0;
    int n_rst0 = 0;
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) if (mv_v[0][d]) n_mv0[d]++;
        if (mv_v[1] != 4'b0) n_mv1++;
        if (mrst0) n_rst0++;
    end

    function automatic int total_mv0();
        return n_mv0[0] + n_mv0[1] + n_mv0[2] + n_mv0[3];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] mask, input int gap);
        {btn_e, btn_s, btn_n, btn_w} = mask;
        tick(1);
        {btn_e, btn_s, btn_n, btn_w} = 4'b0;
        if (gap > 1) tick(gap - 1);
    endtask

    localparam logic [3:0] B_W = 4'b0001, B_N = 4'b0010, B_S = 4'b0100, B_E = 4'b1000;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s_e, s_s, s_w, s_n, s_tot, s_rst, s_mv1, k, cnt, dcnt;

        // Reset state
        tick(3);
        check("reset_status0", int'(st_v[0]), 0);
        check("reset_moves0", int'(moves0), 0);
        check("reset_maze_rst0", int'(mrst0), 0);
        check("reset_mv0", int'(mv_v[0]), 0);
        reset = 1'b0;
        tick(2);

        // Scenario 1: winning path
        s_e = n_mv0[DIR_E]; s_s = n_mv0[DIR_S]; s_w = n_mv0[DIR_W];
        s_tot = total_mv0(); s_rst = n_rst0;
        pulse_start();
        tick(1);
        press(B_E, 4); press(B_S, 4); press(B_W, 4); press(B_E, 4); press(B_E, 4);
        tick(1);
        check("s1_pulses", total_mv0() - s_tot, 5);
        check("s1_east", n_mv0[DIR_E] - s_e, 3);
        check("s1_south", n_mv0[DIR_S] - s_s, 1);
        check("s1_west", n_mv0[DIR_W] - s_w, 1);
        check("s1_maze_rst_count", n_rst0 - s_rst, 1);
        check("s1_won", int'(won0), 1);
        check("s1_moves", int'(moves0), 5);
        check("s1_dut1_lost_at_limit", int'(lost1), 1);
        check("s1_dut1_moves", int'(moves1), 2);

        // Scenario 2: wrong turn loses
        pulse_start();
        tick(1);
        press(B_E, 4); press(B_S, 4); press(B_E, 1);
        k = 0;
        while (!lost0 && k < 6) begin
            tick(1);
            k++;
        end
        check("s2_lose_latency_ok", int'(k >= 1 && k <= 3), 1);
        check("s2_lost", int'(lost0), 1);
        check("s2_moves", int'(moves0), 3);

        // Scenario 3: N and W together -> N only
        pulse_start();
        tick(1);
        s_n = n_mv0[DIR_N]; s_w = n_mv0[DIR_W]; s_tot = total_mv0();
        press(B_N | B_W, 4);
        check("s3_north", n_mv0[DIR_N] - s_n, 1);
        check("s3_west", n_mv0[DIR_W] - s_w, 0);
        check("s3_total", total_mv0() - s_tot, 1);
        check("s3_moves", int'(moves0), 1);

        // Scenario 4: idle timeout
        s_tot = total_mv0();
        pulse_start();
        cnt = 0;
        for (int i = 0; i < 40 && !lost0; i++) begin
            tick(1);
            if (play0) cnt++;
        end
        check("s4_play_cycles", cnt, 10);
        check("s4_lost", int'(lost0), 1);
        check("s4_no_pulses", total_mv0() - s_tot, 0);

        // Scenario 5: move limit, drain, late press ignored (dut1)
        pulse_start();
        tick(1);
        s_mv1 = n_mv1;
        press(B_E, 4);
        btn_e = 1'b1;
        tick(1);
        btn_e = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10 && !lost1; i++) begin
            if (play1) dcnt++;
            btn_e = (i == 1);
            tick(1);
        end
        btn_e = 1'b0;
        check("s5_drain_cycles", dcnt, 3);
        check("s5_lost", int'(lost1), 1);
        check("s5_moves", int'(moves1), 2);
        check("s5_pulses", n_mv1 - s_mv1, 2);
        tick(2);

        // Verdict during drain (dut1)
        pulse_start();
        tick(1);
        press(B_E, 4);
        btn_e = 1'b1;
        tick(1);
        btn_e = 1'b0;
        win1 = 1'b1;
        tick(1);
        win1 = 1'b0;
        check("drain_win", int'(won1), 1);
        tick(2);
        check("won_holds", int'(won1), 1);
        check("won_moves_hold", int'(moves1), 2);

        // Button held through CLEAR gives no move
        btn_n = 1'b1;
        pulse_start();
        tick(3);
        btn_n = 1'b0;
        tick(1);
        check("held_btn_moves0", int'(moves0), 0);
        check("held_btn_moves1", int'(moves1), 0);

        // Scenario 6: reset mid-game
        pulse_start();
        tick(1);
        press(B_E, 4); press(B_S, 4); press(B_W, 4);
        check("s6_moves_before", int'(moves0), 3);
        check("s6_playing_before", int'(play0), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("s6_status", int'(st_v[0]), 0);
        check("s6_moves", int'(moves0), 0);
        check("s6_mv", int'(mv_v[0]), 0);
        check("s6_maze_rst", int'(mrst0), 0);
        tick(2);
        check("s6_idle_stays", int'(play0), 0);
        pulse_start();
        check("s6_restart_maze_rst", int'(mrst0), 1);
        tick(1);
        check("s6_maze_rst_one_cycle", int'(mrst0), 0);
        check("s6_playing", int'(play0), 1);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter MAX_MOVES, default 16, maximum moves per game (1..255).
REQ-002 Parameter TIMEOUT, default 1000, idle cycles in PLAY before forced loss (2..65535).
REQ-003 Parameter DRAIN_CYC, default 3, cycles waited for a maze verdict after the last allowed move.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  level; start a new game or restart the current one.
REQ-007 btn_w, btn_n, btn_s, btn_e  input  1 each  direction buttons, already synchronised to clk.
REQ-008 win, lose  input  1 each  verdict levels from the maze FSM.
REQ-009 mv_w, mv_n, mv_s, mv_e  output  1 each  registered one-cycle move pulses to the maze FSM.
REQ-010 maze_rst  output  1  registered one-cycle reset pulse to the maze FSM.
REQ-011 playing, won, lost  output  1 each  status flags, one-hot or all zero.
REQ-012 moves  output  8  count of moves issued in the current game.

Function
REQ-013 FSM states: IDLE, CLEAR, PLAY, DRAIN, WON, LOST.
REQ-014 Rising edge per button: edge = btn & ~prev; prev is updated every cycle in every state.
REQ-015 IDLE: start -> CLEAR; all other inputs ignored.
REQ-016 CLEAR: maze_rst = 1 for exactly this cycle; moves, idle counter and drain counter cleared; next state PLAY unconditionally.
REQ-017 PLAY priority, highest first: start -> CLEAR; win -> WON; lose -> LOST; edge -> move; idle timeout -> LOST.
REQ-018 Move in PLAY: exactly one mv_* pulse is asserted in the cycle after the edge cycle; fixed priority N > E > S > W; lower-priority edges in the same cycle are discarded.
REQ-019 Each issued move increments moves and clears the idle counter.
REQ-020 A move that makes moves == MAX_MOVES moves the FSM to DRAIN.
REQ-021 Idle counter counts PLAY cycles without an issued move; when it equals TIMEOUT-1 and no higher-priority event is present, next state is LOST.
REQ-022 DRAIN: edges ignored, no mv_* pulses issued; win -> WON; lose -> LOST; start -> CLEAR; after DRAIN_CYC cycles with no verdict -> LOST.
REQ-023 WON and LOST: terminal; buttons, win and lose ignored; start -> CLEAR.
REQ-024 playing = 1 in PLAY and DRAIN; won = 1 in WON; lost = 1 in LOST; all three = 0 in IDLE and CLEAR.
REQ-025 moves never exceeds MAX_MOVES and holds its value in WON and LOST until the next CLEAR.
REQ-026 A button held through CLEAR does not produce a move on entry to PLAY.
REQ-027 If win and lose are both high, win takes precedence.

Reset
REQ-028 When reset is high at a clock edge: state = IDLE; prev = 0; all outputs = 0; all counters = 0.
REQ-029 Reset takes precedence over every other input, including in mid-game and in the DRAIN state.
REQ-030 maze_rst is not asserted by reset itself; the maze is cleared only via CLEAR.

Structure
REQ-031 Package game_pkg holds the state enum (3-bit) and the direction encoding (W, N, S, E), shared with the maze FSM bench.
REQ-032 One sub-module, edge_det: a 4-bit registered rising-edge detector instantiated once for the buttons.
REQ-033 Counters: moves 8-bit saturating; idle counter 16-bit; drain counter 2-bit minimum.

Verification
REQ-034 Scenario 1: reset, start, then E, S, W, E, E presses 4 cycles apart with the maze FSM attached. Required: five mv_* pulses, maze_rst seen once, won = 1, moves = 5.
REQ-035 Scenario 2: start, then E, S, E with the maze attached. Required: lost = 1 within 3 cycles of the third move, moves = 3.
REQ-036 Scenario 3: btn_n and btn_w rise in the same PLAY cycle. Required: only mv_n pulses, moves += 1.
REQ-037 Scenario 4: TIMEOUT = 10, start, no presses. Required: lost = 1 exactly 10 PLAY cycles after CLEAR, no mv_* pulses.
REQ-038 Scenario 5: MAX_MOVES = 2, two E presses with win held low. Required: DRAIN for 3 cycles, then LOST; a third press issues no pulse.
REQ-039 Scenario 6: reset asserted mid-PLAY with moves = 3. Required: next cycle IDLE, moves = 0, all outputs 0; a subsequent start gives maze_rst = 1.
